// File: rtl/check_extrema.sv
// Scale-space extremum detector: walks every interior pixel of two DoG layers
// and reports strict 3x3x2 local maxima/minima for each layer.
module check_extrema #(
   parameter int BIT_DEPTH = 9,
   parameter int DIMENSION = 5,
   localparam int AW = (DIMENSION > 1) ? $clog2(DIMENSION * DIMENSION) : 1,
   localparam int CW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1
) (
   input  logic                        clk,
   input  logic                        rst_in,
   input  logic                        enable,
   input  logic signed [BIT_DEPTH-1:0] first_data,
   input  logic signed [BIT_DEPTH-1:0] second_data,
   output logic [AW-1:0]               first_address,
   output logic [AW-1:0]               second_address,
   output logic                        read,
   output logic [CW-1:0]               read_x,
   output logic [CW-1:0]               read_y,
   output logic [CW-1:0]               x,
   output logic [CW-1:0]               y,
   output logic                        first_is_extremum,
   output logic                        second_is_extremum,
   output logic                        first_is_max,
   output logic                        first_is_min,
   output logic                        second_is_max,
   output logic                        second_is_min,
   output logic                        done_checking,
   output logic [2:0]                  state_number
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      DRAIN  = 3'd2,
      RESULT = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(DIMENSION - 2);

   state_t state, state_next;
   logic [3:0] k;
   logic [CW-1:0] held_x, held_y;
   logic [AW-1:0] held_addr;
   logic [1:0] dx, dy;
   logic [CW-1:0] issue_x, issue_y;
   logic [AW-1:0] issue_addr;
   logic signed [BIT_DEPTH-1:0] c1, c2;
   logic gt1, lt1, gt2, lt2;
   logic own_skip, last_centre, sampling;
   logic upd_gt1, upd_lt1, upd_gt2, upd_lt2;

   // Window offset for the address issued at step k: k=0 is the centre,
   // k=1..9 sweep the 3x3 window row-major.
   always_comb begin
      dx = 2'd1;
      dy = 2'd1;
      case (k)
         4'd1: begin dx = 2'd0; dy = 2'd0; end
         4'd2: begin dx = 2'd1; dy = 2'd0; end
         4'd3: begin dx = 2'd2; dy = 2'd0; end
         4'd4: begin dx = 2'd0; dy = 2'd1; end
         4'd5: begin dx = 2'd1; dy = 2'd1; end
         4'd6: begin dx = 2'd2; dy = 2'd1; end
         4'd7: begin dx = 2'd0; dy = 2'd2; end
         4'd8: begin dx = 2'd1; dy = 2'd2; end
         4'd9: begin dx = 2'd2; dy = 2'd2; end
         default: begin dx = 2'd1; dy = 2'd1; end
      endcase
   end

   assign issue_x    = x + CW'(dx) - CW'(1);
   assign issue_y    = y + CW'(dy) - CW'(1);
   assign issue_addr = AW'(issue_y) * AW'(DIMENSION) + AW'(issue_x);

   assign read           = (state == ISSUE);
   assign read_x         = read ? issue_x : held_x;
   assign read_y         = read ? issue_y : held_y;
   assign first_address  = read ? issue_addr : held_addr;
   assign second_address = first_address;

   // Data arriving at k=3..11 is window sample k-3; sample 4 (k=7) is each
   // layer's own centre, which only takes part in the cross-layer compare.
   assign own_skip = (k == 4'd7);
   assign upd_gt1  = (c1 > second_data) && (own_skip || (c1 > first_data));
   assign upd_lt1  = (c1 < second_data) && (own_skip || (c1 < first_data));
   assign upd_gt2  = (c2 > first_data) && (own_skip || (c2 > second_data));
   assign upd_lt2  = (c2 < first_data) && (own_skip || (c2 < second_data));

   assign sampling    = (state == ISSUE) || (state == DRAIN);
   assign last_centre = (x == LAST) && (y == LAST);

   // Next-state logic for the per-centre issue/drain/result sequence.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = (DIMENSION < 3) ? DONE : ISSUE;
         ISSUE:   if (k == 4'd9) state_next = DRAIN;
         DRAIN:   if (k == 4'd11) state_next = RESULT;
         RESULT:  state_next = last_centre ? DONE : ISSUE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, step counter, centre coordinates, held address and running
   // comparison flags.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state         <= IDLE;
         k             <= 4'd0;
         x             <= '0;
         y             <= '0;
         held_x        <= '0;
         held_y        <= '0;
         held_addr     <= '0;
         c1            <= '0;
         c2            <= '0;
         gt1           <= 1'b0;
         lt1           <= 1'b0;
         gt2           <= 1'b0;
         lt2           <= 1'b0;
         done_checking <= 1'b0;
      end else begin
         state <= state_next;
         k     <= sampling ? k + 4'd1 : 4'd0;
         if (state == ISSUE) begin
            held_x    <= issue_x;
            held_y    <= issue_y;
            held_addr <= issue_addr;
         end
         case (state)
            IDLE: if (enable) begin
               x             <= CW'(1);
               y             <= CW'(1);
               done_checking <= 1'b0;
            end
            RESULT: if (!last_centre) begin
               if (x == LAST) begin
                  x <= CW'(1);
                  y <= y + CW'(1);
               end else begin
                  x <= x + CW'(1);
               end
            end
            DONE: done_checking <= 1'b1;
            default: ;
         endcase
         if (sampling && (k == 4'd2)) begin
            c1  <= first_data;
            c2  <= second_data;
            gt1 <= 1'b1;
            lt1 <= 1'b1;
            gt2 <= 1'b1;
            lt2 <= 1'b1;
         end else if (sampling && (k >= 4'd3) && (k <= 4'd11)) begin
            gt1 <= gt1 && upd_gt1;
            lt1 <= lt1 && upd_lt1;
            gt2 <= gt2 && upd_gt2;
            lt2 <= lt2 && upd_lt2;
         end
      end
   end

   assign first_is_max       = (state == RESULT) && gt1;
   assign first_is_min       = (state == RESULT) && lt1;
   assign second_is_max      = (state == RESULT) && gt2;
   assign second_is_min      = (state == RESULT) && lt2;
   assign first_is_extremum  = first_is_max || first_is_min;
   assign second_is_extremum = second_is_max || second_is_min;
   assign state_number       = state;

endmodule

// File: tb/tb_check_extrema.sv
// Self-checking bench for check_extrema: two-cycle BRAM models plus a
// window-based reference model of the expected extremum flags.
module tb_check_extrema;

   localparam int BD  = 9;
   localparam int DIM = 5;

   logic clk = 1'b0;
   logic rst_in;
   logic enable;
   logic signed [BD-1:0] first_data, second_data;
   logic [4:0] first_address, second_address;
   logic read;
   logic [2:0] read_x, read_y, x, y;
   logic first_is_extremum, second_is_extremum;
   logic first_is_max, first_is_min, second_is_max, second_is_min;
   logic done_checking;
   logic [2:0] state_number;

   logic signed [BD-1:0] mem1 [32];
   logic signed [BD-1:0] mem2 [32];
   logic signed [BD-1:0] pipe1, pipe2;

   int errors = 0;
   int checks = 0;

   check_extrema #(.BIT_DEPTH(BD), .DIMENSION(DIM)) dut (
      .clk(clk), .rst_in(rst_in), .enable(enable),
      .first_data(first_data), .second_data(second_data),
      .first_address(first_address), .second_address(second_address),
      .read(read), .read_x(read_x), .read_y(read_y), .x(x), .y(y),
      .first_is_extremum(first_is_extremum), .second_is_extremum(second_is_extremum),
      .first_is_max(first_is_max), .first_is_min(first_is_min),
      .second_is_max(second_is_max), .second_is_min(second_is_min),
      .done_checking(done_checking), .state_number(state_number)
   );

   always #5 clk = ~clk;

   // Two-cycle read latency BRAMs.
   always @(posedge clk) begin
      pipe1       <= mem1[first_address];
      pipe2       <= mem2[second_address];
      first_data  <= pipe1;
      second_data <= pipe2;
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Expected {first_max, first_min, second_max, second_min} for a centre.
   function automatic logic [3:0] ref_flags(input int cx, input int cy);
      int v1, v2, a, b;
      bit g1, l1, g2, l2;
      v1 = mem1[cy * DIM + cx];
      v2 = mem2[cy * DIM + cx];
      g1 = 1; l1 = 1; g2 = 1; l2 = 1;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            a = mem1[(cy + dy) * DIM + cx + dx];
            b = mem2[(cy + dy) * DIM + cx + dx];
            if (!(dx == 0 && dy == 0)) begin
               g1 &= (v1 > a); l1 &= (v1 < a);
               g2 &= (v2 > b); l2 &= (v2 < b);
            end
            g1 &= (v1 > b); l1 &= (v1 < b);
            g2 &= (v2 > a); l2 &= (v2 < a);
         end
      end
      return {g1, l1, g2, l2};
   endfunction

   function automatic logic [63:0] all_outputs();
      return {31'd0, first_address, second_address, read, read_x, read_y, x, y,
              first_is_extremum, second_is_extremum, first_is_max, first_is_min,
              second_is_max, second_is_min, done_checking, state_number};
   endfunction

   task automatic clear_mems();
      for (int i = 0; i < 32; i++) begin
         mem1[i] = '0;
         mem2[i] = '0;
      end
   endtask

   task automatic fill_random(input int lo, input int hi);
      int v;
      for (int i = 0; i < DIM * DIM; i++) begin
         v = int'($urandom_range(hi - lo)) + lo;
         mem1[i] = BD'(v);
         v = int'($urandom_range(hi - lo)) + lo;
         mem2[i] = BD'(v);
      end
   endtask

   // Pulses enable, then checks every cycle of the scan against the model.
   // abort_at >= 0 stops early (for the mid-scan reset); expected pulse
   // counts < 0 are not checked.
   task automatic apply_stimulus(input string name, input int abort_at,
                                 input int exp_first, input int exp_second);
      int i, k, kk, cx, cy, idx, ex, ey, nf, ns;
      logic [3:0] f;
      logic [5:0] exp_flags;
      nf = 0; ns = 0;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      for (int t = 0; t < 122; t++) begin
         if (abort_at >= 0 && t == abort_at) return;
         check_output($sformatf("%s done t=%0d", name, t), 64'(done_checking),
                      64'(t >= 118));
         if (t < 117) begin
            i = t / 13; k = t % 13;
            cx = 1 + i % 3; cy = 1 + i / 3;
            check_output($sformatf("%s state t=%0d", name, t), 64'(state_number),
                         64'((k <= 9) ? 1 : (k <= 11) ? 2 : 3));
            kk = (k > 9) ? 9 : k;
            if (kk == 0) begin ex = cx; ey = cy; end
            else begin idx = kk - 1; ex = cx - 1 + idx % 3; ey = cy - 1 + idx / 3; end
            if (k <= 11)
               check_output($sformatf("%s addr t=%0d", name, t),
                  64'({read, read_x, read_y, first_address, second_address, x, y}),
                  64'({k <= 9, 3'(ex), 3'(ey), 5'(ey * DIM + ex), 5'(ey * DIM + ex),
                       3'(cx), 3'(cy)}));
            else
               check_output($sformatf("%s centre t=%0d", name, t),
                            64'({read, x, y}), 64'({1'b0, 3'(cx), 3'(cy)}));
            f = ref_flags(cx, cy);
            exp_flags = (k == 12) ? {f[3] | f[2], f[1] | f[0], f} : 6'd0;
         end else begin
            check_output($sformatf("%s state t=%0d", name, t), 64'(state_number),
                         64'((t == 117) ? 4 : 0));
            exp_flags = 6'd0;
         end
         check_output($sformatf("%s flags t=%0d", name, t),
            64'({first_is_extremum, second_is_extremum, first_is_max, first_is_min,
                 second_is_max, second_is_min}), 64'(exp_flags));
         nf += int'(first_is_extremum);
         ns += int'(second_is_extremum);
         enable = (t == 30 || t == 117);
         @(posedge clk); #1;
      end
      enable = 1'b0;
      if (exp_first >= 0) check_output({name, " first pulses"}, 64'(nf), 64'(exp_first));
      if (exp_second >= 0) check_output({name, " second pulses"}, 64'(ns), 64'(exp_second));
   endtask

   initial begin
      rst_in = 1'b1;
      enable = 1'b0;
      clear_mems();
      repeat (3) @(posedge clk);
      #1;
      check_output("reset outputs", all_outputs(), 64'd0);
      rst_in = 1'b0;
      @(posedge clk); #1;

      $display("[TB] all-zero layers");
      apply_stimulus("zero", -1, 0, 0);

      $display("[TB] first layer peak at (2,2)");
      clear_mems(); mem1[12] = 9'sd100;
      apply_stimulus("peak1", -1, 1, 0);

      $display("[TB] second layer dip at (1,3)");
      clear_mems(); mem2[16] = -9'sd50;
      apply_stimulus("dip2", -1, 0, 1);

      $display("[TB] cross-layer dominance at (2,2)");
      clear_mems(); mem1[12] = 9'sd100; mem2[12] = 9'sd120;
      apply_stimulus("cross", -1, 0, 1);

      $display("[TB] tie between (2,2) and (3,2)");
      clear_mems(); mem1[12] = 9'sd100; mem1[13] = 9'sd100;
      apply_stimulus("tie", -1, 0, 0);

      $display("[TB] random narrow-range layers");
      for (int r = 0; r < 3; r++) begin
         fill_random(-3, 3);
         apply_stimulus($sformatf("rand%0d", r), -1, -1, -1);
      end

      $display("[TB] random full-range layers with mid-scan reset");
      fill_random(-256, 255);
      mem1[6] = 9'sd255; mem2[18] = -9'sd256;
      apply_stimulus("abort", 40, -1, -1);
      rst_in = 1'b1;
      @(posedge clk); #1;
      check_output("mid reset outputs", all_outputs(), 64'd0);
      @(posedge clk); #1;
      check_output("mid reset state", 64'(state_number), 64'd0);
      rst_in = 1'b0;
      @(posedge clk); #1;
      apply_stimulus("rerun", -1, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
